// File: rtl/fp_issue_pkg.sv
// Shared definitions for the FP pair issuer: operand width and FSM state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fp_issue_pkg;

  localparam int FP_W = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/fp_op_fifo.sv
// Operand FIFO with full/empty flags, simultaneous push/pop and empty bypass.
// Latency: a push into an empty FIFO is visible on head_dat in the same cycle.
// Backpressure: none upstream; a push to a full FIFO that is not popping is dropped.
//
// Ports:
//   clk, rst_n          clock, async active-low reset (empties the FIFO)
//   push, push_dat      write strobe and word
//   pop                 consume the head word (caller only pops when a word is present)
//   head_dat            head of queue, or push_dat when empty
//   full, empty         occupancy flags (registered state)
module fp_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;
  logic          pass_thru;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A word pushed and popped in the same cycle while empty never touches storage.
  assign pass_thru = pop && empty && push;
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || pop) && !pass_thru;

  assign head_dat = empty ? push_dat : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_pair_issuer.sv
// Pairs A/B operand streams and issues them to an AXI-Stream FP core, credit-limited.
// Latency: 1 cycle from the second operand's vld to both tvalids (when idle with credit).
// Backpressure: per-channel tready holds that channel; operand inputs are never stalled
//               (overflow is dropped and flagged), result channel is always ready.
//
// Ports:
//   clk, rst_n                              clock, async active-low reset
//   op_a/op_a_vld, op_b/op_b_vld            operand pushes
//   s_axis_a_*, s_axis_b_*                  operand channels to the FP core
//   m_axis_result_*                         result channel from the FP core
//   result/result_vld                       registered copy of core results
//   ovf_err, unf_err                        sticky overflow / underflow flags
//   issue_cnt, result_cnt                   present only with FP_ISSUER_STATS_EN defined
module fp_pair_issuer
  import fp_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [FP_W-1:0] op_a,
  input  logic            op_a_vld,
  input  logic [FP_W-1:0] op_b,
  input  logic            op_b_vld,
  output logic [FP_W-1:0] s_axis_a_tdata,
  output logic            s_axis_a_tvalid,
  input  logic            s_axis_a_tready,
  output logic [FP_W-1:0] s_axis_b_tdata,
  output logic            s_axis_b_tvalid,
  input  logic            s_axis_b_tready,
  input  logic [FP_W-1:0] m_axis_result_tdata,
  input  logic            m_axis_result_tvalid,
  output logic            m_axis_result_tready,
  output logic [FP_W-1:0] result,
  output logic            result_vld,
  output logic            ovf_err,
  output logic            unf_err
`ifdef FP_ISSUER_STATS_EN
  ,
  output logic [31:0]     issue_cnt,
  output logic [31:0]     result_cnt
`endif
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] MAX_OUT_V = OW'(MAX_OUT);

  state_t          state;
  state_t          state_nxt;
  logic            load;
  logic            pair_done;
  logic            can_issue;
  logic [FP_W-1:0] a_head;
  logic [FP_W-1:0] b_head;
  logic            a_full;
  logic            a_empty;
  logic            b_full;
  logic            b_empty;
  logic            a_avail;
  logic            b_avail;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   out_nxt;
  logic            unf_hit;
  logic            ovf_hit;

  assign m_axis_result_tready = 1'b1;

  fp_op_fifo #(.DEPTH(DEPTH), .W(FP_W)) u_fifo_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (op_a_vld),
    .push_dat (op_a),
    .pop      (load),
    .head_dat (a_head),
    .full     (a_full),
    .empty    (a_empty)
  );

  fp_op_fifo #(.DEPTH(DEPTH), .W(FP_W)) u_fifo_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (op_b_vld),
    .push_dat (op_b),
    .pop      (load),
    .head_dat (b_head),
    .full     (b_full),
    .empty    (b_empty)
  );

  // An operand arriving this cycle can be issued immediately via the FIFO bypass.
  assign a_avail = !a_empty || op_a_vld;
  assign b_avail = !b_empty || op_b_vld;

  assign ovf_hit = (op_a_vld && a_full && !load) || (op_b_vld && b_full && !load);

  // A channel is finished once its tvalid is low or its handshake happens now.
  assign pair_done = (state == ISSUE) &&
                     (!s_axis_a_tvalid || s_axis_a_tready) &&
                     (!s_axis_b_tvalid || s_axis_b_tready);

  always_comb begin
    out_nxt = outstanding;
    unf_hit = 1'b0;
    case ({pair_done, m_axis_result_tvalid})
      2'b10: out_nxt = outstanding + OW'(1);
      2'b01: begin
        if (outstanding == '0) unf_hit = 1'b1;
        else                   out_nxt = outstanding - OW'(1);
      end
      default: out_nxt = outstanding;
    endcase
  end

  // Credit is judged on next cycle's count so a completing pair is already
  // charged and a returning result frees its slot without an extra cycle.
  assign can_issue = a_avail && b_avail && (out_nxt < MAX_OUT_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (can_issue) begin
          state_nxt = ISSUE;
          load      = 1'b1;
        end
      end
      ISSUE: begin
        if (pair_done) begin
          if (can_issue) load      = 1'b1;
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axis_a_tdata  <= '0;
      s_axis_a_tvalid <= 1'b0;
      s_axis_b_tdata  <= '0;
      s_axis_b_tvalid <= 1'b0;
    end else if (load) begin
      s_axis_a_tdata  <= a_head;
      s_axis_a_tvalid <= 1'b1;
      s_axis_b_tdata  <= b_head;
      s_axis_b_tvalid <= 1'b1;
    end else begin
      if (s_axis_a_tvalid && s_axis_a_tready) s_axis_a_tvalid <= 1'b0;
      if (s_axis_b_tvalid && s_axis_b_tready) s_axis_b_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      ovf_err     <= 1'b0;
      unf_err     <= 1'b0;
      result      <= '0;
      result_vld  <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      if (ovf_hit) ovf_err <= 1'b1;
      if (unf_hit) unf_err <= 1'b1;
      result_vld <= m_axis_result_tvalid;
      if (m_axis_result_tvalid) result <= m_axis_result_tdata;
    end
  end

`ifdef FP_ISSUER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt  <= '0;
      result_cnt <= '0;
    end else begin
      if (pair_done)            issue_cnt  <= issue_cnt + 32'd1;
      if (m_axis_result_tvalid) result_cnt <= result_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_pair_issuer.sv
// Directed bench for fp_pair_issuer: each task resets, drives a scenario and checks inline.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Cycle n is the interval following the n-th rising edge of the scenario.
module tb_fp_pair_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] op_a = '0;
  logic        op_a_vld = 1'b0;
  logic [63:0] op_b = '0;
  logic        op_b_vld = 1'b0;
  logic [63:0] s_axis_a_tdata;
  logic        s_axis_a_tvalid;
  logic        s_axis_a_tready = 1'b1;
  logic [63:0] s_axis_b_tdata;
  logic        s_axis_b_tvalid;
  logic        s_axis_b_tready = 1'b1;
  logic [63:0] m_axis_result_tdata = '0;
  logic        m_axis_result_tvalid = 1'b0;
  logic        m_axis_result_tready;
  logic [63:0] result;
  logic        result_vld;
  logic        ovf_err;
  logic        unf_err;
`ifdef FP_ISSUER_STATS_EN
  logic [31:0] issue_cnt;
  logic [31:0] result_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  fp_pair_issuer #(.DEPTH(4), .MAX_OUT(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .op_a                 (op_a),
    .op_a_vld             (op_a_vld),
    .op_b                 (op_b),
    .op_b_vld             (op_b_vld),
    .s_axis_a_tdata       (s_axis_a_tdata),
    .s_axis_a_tvalid      (s_axis_a_tvalid),
    .s_axis_a_tready      (s_axis_a_tready),
    .s_axis_b_tdata       (s_axis_b_tdata),
    .s_axis_b_tvalid      (s_axis_b_tvalid),
    .s_axis_b_tready      (s_axis_b_tready),
    .m_axis_result_tdata  (m_axis_result_tdata),
    .m_axis_result_tvalid (m_axis_result_tvalid),
    .m_axis_result_tready (m_axis_result_tready),
    .result               (result),
    .result_vld           (result_vld),
    .ovf_err              (ovf_err),
    .unf_err              (unf_err)
`ifdef FP_ISSUER_STATS_EN
    ,
    .issue_cnt            (issue_cnt),
    .result_cnt           (result_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    op_a_vld = 1'b0;
    op_b_vld = 1'b0;
    s_axis_a_tready = 1'b1;
    s_axis_b_tready = 1'b1;
    m_axis_result_tvalid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total_cnt++; if (s_axis_a_tvalid !== 1'b0) $display("FAIL rst_a_tvalid got %0h exp 0", s_axis_a_tvalid); else pass_cnt++;
    total_cnt++; if (s_axis_b_tvalid !== 1'b0) $display("FAIL rst_b_tvalid got %0h exp 0", s_axis_b_tvalid); else pass_cnt++;
    total_cnt++; if (s_axis_a_tdata !== 64'h0) $display("FAIL rst_a_tdata got %0h exp 0", s_axis_a_tdata); else pass_cnt++;
    total_cnt++; if (s_axis_b_tdata !== 64'h0) $display("FAIL rst_b_tdata got %0h exp 0", s_axis_b_tdata); else pass_cnt++;
    total_cnt++; if (result !== 64'h0) $display("FAIL rst_result got %0h exp 0", result); else pass_cnt++;
    total_cnt++; if (result_vld !== 1'b0) $display("FAIL rst_result_vld got %0h exp 0", result_vld); else pass_cnt++;
    total_cnt++; if (ovf_err !== 1'b0) $display("FAIL rst_ovf got %0h exp 0", ovf_err); else pass_cnt++;
    total_cnt++; if (unf_err !== 1'b0) $display("FAIL rst_unf got %0h exp 0", unf_err); else pass_cnt++;
    total_cnt++; if (m_axis_result_tready !== 1'b1) $display("FAIL res_tready got %0h exp 1", m_axis_result_tready); else pass_cnt++;
    do_reset();
  endtask

  // A at cycle 0, B at cycle 3: both tvalid in cycle 4 only.
  task automatic test_single_pair();
    do_reset();
    op_a = 64'h3FF0000000000000; op_a_vld = 1'b1;
    step();
    op_a_vld = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin op_b = 64'h4000000000000000; op_b_vld = 1'b1; end
      total_cnt++; if (s_axis_a_tvalid !== 1'b0) $display("FAIL single_wait_c%0d got %0h exp 0", c, s_axis_a_tvalid); else pass_cnt++;
      step();
    end
    op_b_vld = 1'b0;
    total_cnt++; if (s_axis_a_tvalid !== 1'b1) $display("FAIL single_a_vld got %0h exp 1", s_axis_a_tvalid); else pass_cnt++;
    total_cnt++; if (s_axis_b_tvalid !== 1'b1) $display("FAIL single_b_vld got %0h exp 1", s_axis_b_tvalid); else pass_cnt++;
    total_cnt++; if (s_axis_a_tdata !== 64'h3FF0000000000000) $display("FAIL single_a_dat got %0h exp 3ff0000000000000", s_axis_a_tdata); else pass_cnt++;
    total_cnt++; if (s_axis_b_tdata !== 64'h4000000000000000) $display("FAIL single_b_dat got %0h exp 4000000000000000", s_axis_b_tdata); else pass_cnt++;
    step();
    total_cnt++; if (s_axis_a_tvalid !== 1'b0) $display("FAIL single_a_drop got %0h exp 0", s_axis_a_tvalid); else pass_cnt++;
    total_cnt++; if (s_axis_b_tvalid !== 1'b0) $display("FAIL single_b_drop got %0h exp 0", s_axis_b_tvalid); else pass_cnt++;
    m_axis_result_tdata = 64'h4008000000000000; m_axis_result_tvalid = 1'b1;
    step();
    m_axis_result_tvalid = 1'b0;
    total_cnt++; if (result_vld !== 1'b1) $display("FAIL single_res_vld got %0h exp 1", result_vld); else pass_cnt++;
    total_cnt++; if (result !== 64'h4008000000000000) $display("FAIL single_res got %0h exp 4008000000000000", result); else pass_cnt++;
    step();
    total_cnt++; if (result_vld !== 1'b0) $display("FAIL single_res_pulse got %0h exp 0", result_vld); else pass_cnt++;
    total_cnt++; if (result !== 64'h4008000000000000) $display("FAIL single_res_hold got %0h exp 4008000000000000", result); else pass_cnt++;
    total_cnt++; if (unf_err !== 1'b0) $display("FAIL single_unf got %0h exp 0", unf_err); else pass_cnt++;
  endtask

  // Four pairs on consecutive cycles issue on four consecutive cycles.
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      op_a = 64'h1000 + 64'(i); op_b = 64'h2000 + 64'(i);
      op_a_vld = 1'b1; op_b_vld = 1'b1;
      step();
      total_cnt++; if (s_axis_a_tvalid !== 1'b1 || s_axis_b_tvalid !== 1'b1) $display("FAIL b2b_vld_%0d got %0h/%0h exp 1/1", i, s_axis_a_tvalid, s_axis_b_tvalid); else pass_cnt++;
      total_cnt++; if (s_axis_a_tdata !== 64'h1000 + 64'(i)) $display("FAIL b2b_a_%0d got %0h exp %0h", i, s_axis_a_tdata, 64'h1000 + 64'(i)); else pass_cnt++;
      total_cnt++; if (s_axis_b_tdata !== 64'h2000 + 64'(i)) $display("FAIL b2b_b_%0d got %0h exp %0h", i, s_axis_b_tdata, 64'h2000 + 64'(i)); else pass_cnt++;
    end
    op_a_vld = 1'b0; op_b_vld = 1'b0;
    step();
    total_cnt++; if (s_axis_a_tvalid !== 1'b0) $display("FAIL b2b_end got %0h exp 0", s_axis_a_tvalid); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      m_axis_result_tdata = 64'h5000 + 64'(i); m_axis_result_tvalid = 1'b1;
      step();
      total_cnt++; if (result_vld !== 1'b1 || result !== 64'h5000 + 64'(i)) $display("FAIL b2b_res_%0d got %0h/%0h exp 1/%0h", i, result_vld, result, 64'h5000 + 64'(i)); else pass_cnt++;
    end
    m_axis_result_tvalid = 1'b0;
    step();
    total_cnt++; if (unf_err !== 1'b0) $display("FAIL b2b_unf_early got %0h exp 0", unf_err); else pass_cnt++;
    m_axis_result_tvalid = 1'b1;
    step();
    m_axis_result_tvalid = 1'b0;
    total_cnt++; if (unf_err !== 1'b1) $display("FAIL b2b_unf_extra got %0h exp 1", unf_err); else pass_cnt++;
  endtask

  // B stalled for cycles 1..3 while A is accepted at once.
  task automatic test_stall();
    do_reset();
    s_axis_a_tready = 1'b1; s_axis_b_tready = 1'b0;
    op_a = 64'hAAAA; op_b = 64'hBBBB; op_a_vld = 1'b1; op_b_vld = 1'b1;
    step();
    op_a_vld = 1'b0; op_b_vld = 1'b0;
    total_cnt++; if (s_axis_a_tvalid !== 1'b1 || s_axis_b_tvalid !== 1'b1) $display("FAIL stall_c1 got %0h/%0h exp 1/1", s_axis_a_tvalid, s_axis_b_tvalid); else pass_cnt++;
    step();
    total_cnt++; if (s_axis_a_tvalid !== 1'b0) $display("FAIL stall_a_drop got %0h exp 0", s_axis_a_tvalid); else pass_cnt++;
    total_cnt++; if (s_axis_b_tvalid !== 1'b1 || s_axis_b_tdata !== 64'hBBBB) $display("FAIL stall_b_c2 got %0h/%0h exp 1/bbbb", s_axis_b_tvalid, s_axis_b_tdata); else pass_cnt++;
    step();
    total_cnt++; if (s_axis_b_tvalid !== 1'b1 || s_axis_b_tdata !== 64'hBBBB) $display("FAIL stall_b_c3 got %0h/%0h exp 1/bbbb", s_axis_b_tvalid, s_axis_b_tdata); else pass_cnt++;
    step();
    s_axis_b_tready = 1'b1;
    total_cnt++; if (s_axis_b_tvalid !== 1'b1 || s_axis_b_tdata !== 64'hBBBB) $display("FAIL stall_b_c4 got %0h/%0h exp 1/bbbb", s_axis_b_tvalid, s_axis_b_tdata); else pass_cnt++;
    step();
    total_cnt++; if (s_axis_b_tvalid !== 1'b0 || s_axis_a_tvalid !== 1'b0) $display("FAIL stall_done got %0h/%0h exp 0/0", s_axis_a_tvalid, s_axis_b_tvalid); else pass_cnt++;
    m_axis_result_tvalid = 1'b1;
    step();
    m_axis_result_tvalid = 1'b0;
    total_cnt++; if (unf_err !== 1'b0) $display("FAIL stall_one_pair got %0h exp 0", unf_err); else pass_cnt++;
    m_axis_result_tvalid = 1'b1;
    step();
    m_axis_result_tvalid = 1'b0;
    total_cnt++; if (unf_err !== 1'b1) $display("FAIL stall_only_one got %0h exp 1", unf_err); else pass_cnt++;
  endtask

  // Nine pairs with no results: eight issue, the ninth waits for a result.
  task automatic test_credit();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      op_a = 64'h3000 + 64'(i); op_b = 64'h4000 + 64'(i);
      op_a_vld = 1'b1; op_b_vld = 1'b1;
      step();
      if (i < 8) begin
        total_cnt++; if (s_axis_a_tvalid !== 1'b1 || s_axis_a_tdata !== 64'h3000 + 64'(i)) $display("FAIL credit_issue_%0d got %0h/%0h exp 1/%0h", i, s_axis_a_tvalid, s_axis_a_tdata, 64'h3000 + 64'(i)); else pass_cnt++;
      end else begin
        total_cnt++; if (s_axis_a_tvalid !== 1'b0) $display("FAIL credit_block got %0h exp 0", s_axis_a_tvalid); else pass_cnt++;
      end
    end
    op_a_vld = 1'b0; op_b_vld = 1'b0;
    step();
    step();
    total_cnt++; if (s_axis_a_tvalid !== 1'b0) $display("FAIL credit_hold got %0h exp 0", s_axis_a_tvalid); else pass_cnt++;
    m_axis_result_tvalid = 1'b1;
    step();
    m_axis_result_tvalid = 1'b0;
    total_cnt++; if (s_axis_a_tvalid !== 1'b1 || s_axis_b_tvalid !== 1'b1) $display("FAIL credit_release got %0h/%0h exp 1/1", s_axis_a_tvalid, s_axis_b_tvalid); else pass_cnt++;
    total_cnt++; if (s_axis_a_tdata !== 64'h3008 || s_axis_b_tdata !== 64'h4008) $display("FAIL credit_ninth got %0h/%0h exp 3008/4008", s_axis_a_tdata, s_axis_b_tdata); else pass_cnt++;
    step();
    total_cnt++; if (s_axis_a_tvalid !== 1'b0) $display("FAIL credit_after got %0h exp 0", s_axis_a_tvalid); else pass_cnt++;
  endtask

  // Five A pushes into a depth-4 FIFO: overflow flagged, fifth word lost.
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      op_a = 64'hA0 + 64'(i); op_a_vld = 1'b1;
      step();
      if (i == 3) begin
        total_cnt++; if (ovf_err !== 1'b0) $display("FAIL ovf_early got %0h exp 0", ovf_err); else pass_cnt++;
      end
    end
    op_a_vld = 1'b0;
    total_cnt++; if (ovf_err !== 1'b1) $display("FAIL ovf_set got %0h exp 1", ovf_err); else pass_cnt++;
    for (int j = 0; j < 5; j++) begin
      op_b = 64'hB0 + 64'(j); op_b_vld = 1'b1;
      step();
      if (j < 4) begin
        total_cnt++; if (s_axis_a_tvalid !== 1'b1 || s_axis_a_tdata !== 64'hA0 + 64'(j) || s_axis_b_tdata !== 64'hB0 + 64'(j)) $display("FAIL ovf_pair_%0d got %0h/%0h/%0h exp 1/%0h/%0h", j, s_axis_a_tvalid, s_axis_a_tdata, s_axis_b_tdata, 64'hA0 + 64'(j), 64'hB0 + 64'(j)); else pass_cnt++;
      end else begin
        total_cnt++; if (s_axis_a_tvalid !== 1'b0) $display("FAIL ovf_fifth_issued got %0h exp 0", s_axis_a_tvalid); else pass_cnt++;
      end
    end
    op_b_vld = 1'b0;
    step();
    total_cnt++; if (s_axis_a_tvalid !== 1'b0 || ovf_err !== 1'b1) $display("FAIL ovf_final got %0h/%0h exp 0/1", s_axis_a_tvalid, ovf_err); else pass_cnt++;
  endtask

  // Reset while issuing drops the pair and buffered operands; later results underflow.
  task automatic test_reset_mid();
    do_reset();
    s_axis_a_tready = 1'b0; s_axis_b_tready = 1'b0;
    op_a = 64'h77; op_b = 64'h88; op_a_vld = 1'b1; op_b_vld = 1'b1;
    step();
    op_a = 64'h99; op_b_vld = 1'b0;
    total_cnt++; if (s_axis_a_tvalid !== 1'b1) $display("FAIL rmid_issue got %0h exp 1", s_axis_a_tvalid); else pass_cnt++;
    step();
    op_a_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (s_axis_a_tvalid !== 1'b0 || s_axis_b_tvalid !== 1'b0) $display("FAIL rmid_async got %0h/%0h exp 0/0", s_axis_a_tvalid, s_axis_b_tvalid); else pass_cnt++;
    total_cnt++; if (s_axis_a_tdata !== 64'h0) $display("FAIL rmid_tdata got %0h exp 0", s_axis_a_tdata); else pass_cnt++;
    step();
    rst_n = 1'b1;
    s_axis_a_tready = 1'b1; s_axis_b_tready = 1'b1;
    op_b = 64'hCC; op_b_vld = 1'b1;
    step();
    op_b_vld = 1'b0;
    step();
    total_cnt++; if (s_axis_a_tvalid !== 1'b0) $display("FAIL rmid_flushed got %0h exp 0", s_axis_a_tvalid); else pass_cnt++;
    m_axis_result_tdata = 64'hDEAD; m_axis_result_tvalid = 1'b1;
    step();
    m_axis_result_tvalid = 1'b0;
    total_cnt++; if (result_vld !== 1'b1 || result !== 64'hDEAD) $display("FAIL rmid_res got %0h/%0h exp 1/dead", result_vld, result); else pass_cnt++;
    total_cnt++; if (unf_err !== 1'b1) $display("FAIL rmid_unf got %0h exp 1", unf_err); else pass_cnt++;
    step();
    total_cnt++; if (result_vld !== 1'b0) $display("FAIL rmid_res_pulse got %0h exp 0", result_vld); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_stall();
    test_credit();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
